// File: rtl/ahb_lite_slave_mem_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-lane helpers for the
// word-addressed AHB-Lite memory subordinate.
package ahb_lite_slave_mem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      HSIZE_HALF: return !lsb[0];
      HSIZE_WORD: return lsb == 2'b00;
      default:    return 1'b1;
    endcase
  endfunction

  // Little-endian byte lanes touched by a legal transfer.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      HSIZE_BYTE: return 4'b0001 << lsb;
      HSIZE_HALF: return lsb[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-Lite bus bundle between a master/interconnect and one subordinate.
interface ahb_lite_slave_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic [DATA_W-1:0] hrdata;
  logic              hreadyout;
  logic              hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_lite_slave_mem_sram.sv
// Word-organised storage with per-byte write enables and an asynchronous read port.
module ahb_lite_slave_mem_sram #(
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: storage has no reset; contents must survive a bus reset and a
  // resettable array would not map onto RAM macros.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory subordinate: address-phase capture, range/size checking,
// programmable wait states, two-cycle ERROR response and byte-lane writes.
module ahb_lite_slave_mem
  import ahb_lite_slave_mem_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                MEM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  ahb_lite_slave_mem_if.slave  bus
);

  localparam int                WORD_W = $clog2(MEM_DEPTH);
  localparam int                OFF_W  = WORD_W + 2;
  localparam int                CNT_W  = 4;
  localparam logic [ADDR_W-1:0] RANGE  = ADDR_W'(MEM_DEPTH * 4);

  state_t             state;
  logic               hreadyout_q;
  logic               hresp_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [OFF_W-1:0]   addr_q;
  logic               write_q;
  logic [2:0]         size_q;
  logic [DATA_W-1:0]  hrdata_q;
  logic [DATA_W-1:0]  rdata;
  logic [3:0]         we;

  // The extra MSB of diff is the borrow, i.e. haddr below BASE_ADDR.
  logic [ADDR_W:0]    diff;
  logic               accept;
  logic               addr_err;

  assign accept   = bus.hsel & bus.hready & bus.htrans[1];
  assign diff     = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
  assign addr_err = diff[ADDR_W] || (diff[ADDR_W-1:0] >= RANGE) ||
                    (bus.hsize > HSIZE_WORD) || !is_aligned(bus.hsize, bus.haddr[1:0]);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state       <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      wait_cnt    <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      hrdata_q    <= '0;
    end else begin
      if (state == S_DATA && !write_q) hrdata_q <= rdata;
      unique case (state)
        S_IDLE, S_DATA: begin
          if (accept) begin
            addr_q  <= diff[OFF_W-1:0];
            write_q <= bus.hwrite;
            size_q  <= bus.hsize;
            if (addr_err) begin
              state       <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state       <= S_WAIT;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_OKAY;
              wait_cnt    <= CNT_W'(WAIT_STATES - 1);
            end else begin
              state       <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= HRESP_OKAY;
            end
          end else begin
            state       <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state       <= S_DATA;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_ERR1: begin
          state       <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        S_ERR2: begin
          state       <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
        default: begin
          state       <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // A write commits on the edge closing its data phase unless reset aborts it.
  assign we = (state == S_DATA && write_q && !hreset) ? byte_lanes(size_q, addr_q[1:0]) : 4'b0000;

  ahb_lite_slave_mem_sram #(
    .DEPTH (MEM_DEPTH),
    .AW    (WORD_W)
  ) u_sram (
    .clk   (hclk),
    .addr  (addr_q[OFF_W-1:2]),
    .we    (we),
    .wdata (bus.hwdata),
    .rdata (rdata)
  );

  assign bus.hrdata    = (state == S_DATA && !write_q) ? rdata : hrdata_q;
  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;

  // Burst type and htrans[0] carry no information this subordinate acts on.
  logic unused_ok;
  assign unused_ok = ^{bus.hburst, bus.htrans[0], diff[ADDR_W-1:OFF_W]};

endmodule
